// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM driving external memory and ALU
module control_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [11:0] pc_out,
  output logic [15:0] ac_out,
  output logic [15:0] ir_out,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPFETCH, EXECUTE, STORE, HALT} state_t;
  state_t state;
  logic [11:0] pc;
  logic [15:0] ac;
  logic [15:0] ir;
  logic [3:0]  dop;
  logic [11:0] daddr;
  logic [11:0] opaddr;
  assign dop        = mem_rdata[15:12];
  assign daddr      = mem_rdata[11:0];
  assign opaddr     = (ir[15:12] == 4'd3) ? {4'b0, ir[7:0]} : ir[11:0];
  assign mem_we     = (state == STORE) && !reset;
  assign mem_wdata  = ac;
  assign alu_a      = ac;
  assign alu_b      = mem_rdata;
  assign alu_opcode = ir[11:8];
  assign pc_out     = pc;
  assign ac_out     = ac;
  assign ir_out     = ir;
  always_comb begin
    mem_addr = reset ? 16'h0000
             : (state == FETCH) ? {4'b0, pc}
             : (state == OPFETCH || state == STORE) ? {4'b0, opaddr}
             : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ac      <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= run ? FETCH : IDLE;
        FETCH:   state <= DECODE;
        DECODE: begin
          ir <= mem_rdata;
          pc <= pc + 12'd1;
          case (dop)
            4'd0: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            4'd1, 4'd3: state <= OPFETCH;
            4'd2: state <= STORE;
            4'd4: begin
              pc    <= daddr;
              state <= FETCH;
            end
            4'd5: begin
              if (ac == 16'h0000) pc <= daddr;
              state <= FETCH;
            end
            4'd6: begin
              ac    <= {4'b0, daddr};
              state <= FETCH;
            end
            default: begin
              state   <= HALT;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          endcase
        end
        OPFETCH: state <= EXECUTE;
        EXECUTE: begin
          ac    <= (ir[15:12] == 4'd3) ? alu_result : mem_rdata;
          state <= FETCH;
        end
        STORE:   state <= FETCH;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scenario tests with a behavioural memory and ALU
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, ac_out, ir_out;
  logic        mem_we, halted, illegal;
  logic [3:0]  alu_opcode;
  logic [11:0] pc_out;
  logic        clr = 1'b0;
  logic        ld_we = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] mem [0:4095];
  int          we_cnt = 0;
  int          checks = 0;
  int          fails = 0;
  control_sequencer #(.RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc_out(pc_out), .ac_out(ac_out), .ir_out(ir_out), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_result = (alu_opcode == 4'd0) ? alu_a + alu_b
               : (alu_opcode == 4'd1) ? alu_a - alu_b
               : (alu_opcode == 4'd2) ? (alu_a & alu_b)
               : alu_b;
  end
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      we_cnt <= 0;
    end else if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
    mem_rdata <= mem[mem_addr[11:0]];
  end
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask
  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
  endtask
  task automatic start();
    reset = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== 12'h000) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 12'h000); end
    checks++; if (ac_out !== 16'h0000) begin fails++; $display("FAIL reset_ac got=%h exp=%h", ac_out, 16'h0000); end
    checks++; if (ir_out !== 16'h0000) begin fails++; $display("FAIL reset_ir got=%h exp=%h", ir_out, 16'h0000); end
    checks++; if ({halted, illegal, mem_we} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=%b", {halted, illegal, mem_we}, 3'b000); end
    checks++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got=%h exp=%h", mem_addr, 16'h0000); end
    poke(12'h000, 16'h6005);
    reset = 1'b0;
    tick(4);
    checks++; if ({pc_out, ac_out} !== 28'h0) begin fails++; $display("FAIL idle_no_run got=%h exp=%h", {pc_out, ac_out}, 28'h0); end
  endtask
  task automatic test_loadi_store();
    do_reset();
    poke(12'h000, 16'h6005);
    poke(12'h001, 16'h200A);
    poke(12'h002, 16'h0000);
    start();
    tick(2);
    checks++; if (ac_out !== 16'h0005) begin fails++; $display("FAIL loadi_ac got=%h exp=%h", ac_out, 16'h0005); end
    checks++; if (pc_out !== 12'h001) begin fails++; $display("FAIL loadi_pc got=%h exp=%h", pc_out, 12'h001); end
    tick(2);
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h000A, 16'h0005}) begin fails++; $display("FAIL store_bus got=%h exp=%h", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h000A, 16'h0005}); end
    tick();
    checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL store_we_drop got=%b exp=%b", mem_we, 1'b0); end
    checks++; if (mem[10] !== 16'h0005) begin fails++; $display("FAIL store_mem got=%h exp=%h", mem[10], 16'h0005); end
    tick(2);
    checks++; if ({halted, illegal} !== 2'b10) begin fails++; $display("FAIL halt_flags got=%b exp=%b", {halted, illegal}, 2'b10); end
    checks++; if (pc_out !== 12'h003) begin fails++; $display("FAIL halt_pc got=%h exp=%h", pc_out, 12'h003); end
    tick(3);
    checks++; if (we_cnt !== 1) begin fails++; $display("FAIL store_we_count got=%0d exp=%0d", we_cnt, 1); end
  endtask
  task automatic test_load_alu();
    do_reset();
    poke(12'h000, 16'h1010);
    poke(12'h001, 16'h3014);
    poke(12'h002, 16'h3115);
    poke(12'h003, 16'h3116);
    poke(12'h004, 16'h0000);
    poke(12'h010, 16'h0007);
    poke(12'h014, 16'h0003);
    poke(12'h015, 16'h0004);
    poke(12'h016, 16'h0007);
    start();
    tick(2);
    checks++; if (mem_addr !== 16'h0010) begin fails++; $display("FAIL load_opaddr got=%h exp=%h", mem_addr, 16'h0010); end
    tick(2);
    checks++; if (ac_out !== 16'h0007) begin fails++; $display("FAIL load_ac got=%h exp=%h", ac_out, 16'h0007); end
    tick(2);
    checks++; if (mem_addr !== 16'h0014) begin fails++; $display("FAIL alu_opaddr got=%h exp=%h", mem_addr, 16'h0014); end
    tick();
    checks++; if ({alu_opcode, alu_a, alu_b} !== {4'h0, 16'h0007, 16'h0003}) begin fails++; $display("FAIL alu_exec_bus got=%h exp=%h", {alu_opcode, alu_a, alu_b}, {4'h0, 16'h0007, 16'h0003}); end
    tick();
    checks++; if (ac_out !== 16'h000A) begin fails++; $display("FAIL alu_add got=%h exp=%h", ac_out, 16'h000A); end
    tick(4);
    checks++; if (ac_out !== 16'h0006) begin fails++; $display("FAIL alu_sub got=%h exp=%h", ac_out, 16'h0006); end
    tick(4);
    checks++; if (ac_out !== 16'hFFFF) begin fails++; $display("FAIL alu_wrap got=%h exp=%h", ac_out, 16'hFFFF); end
  endtask
  task automatic test_jz();
    do_reset();
    poke(12'h000, 16'h6000);
    poke(12'h001, 16'h5040);
    poke(12'h040, 16'h6001);
    poke(12'h041, 16'h5040);
    poke(12'h042, 16'h0000);
    start();
    tick(4);
    checks++; if (pc_out !== 12'h040) begin fails++; $display("FAIL jz_taken got=%h exp=%h", pc_out, 12'h040); end
    tick(4);
    checks++; if ({ac_out, pc_out} !== {16'h0001, 12'h042}) begin fails++; $display("FAIL jz_not_taken got=%h exp=%h", {ac_out, pc_out}, {16'h0001, 12'h042}); end
  endtask
  task automatic test_pc_wrap();
    do_reset();
    poke(12'h000, 16'h4FFF);
    poke(12'hFFF, 16'h6001);
    start();
    tick(2);
    checks++; if (pc_out !== 12'hFFF) begin fails++; $display("FAIL jump_pc got=%h exp=%h", pc_out, 12'hFFF); end
    tick(2);
    checks++; if ({pc_out, ac_out} !== {12'h000, 16'h0001}) begin fails++; $display("FAIL pc_wrap got=%h exp=%h", {pc_out, ac_out}, {12'h000, 16'h0001}); end
  endtask
  task automatic test_illegal();
    do_reset();
    poke(12'h000, 16'h7000);
    start();
    tick(2);
    checks++; if ({halted, illegal, pc_out} !== {2'b11, 12'h001}) begin fails++; $display("FAIL illegal_halt got=%h exp=%h", {halted, illegal, pc_out}, {2'b11, 12'h001}); end
    run = 1'b1;
    tick(3);
    run = 1'b0;
    tick(2);
    checks++; if ({halted, illegal, mem_we, pc_out, ir_out} !== {3'b110, 12'h001, 16'h7000}) begin fails++; $display("FAIL illegal_run_ignored got=%h exp=%h", {halted, illegal, mem_we, pc_out, ir_out}, {3'b110, 12'h001, 16'h7000}); end
  endtask
  task automatic test_reset_in_store();
    do_reset();
    poke(12'h000, 16'h6009);
    poke(12'h001, 16'h2030);
    poke(12'h030, 16'h1234);
    start();
    tick(4);
    checks++; if (mem_we !== 1'b1) begin fails++; $display("FAIL pre_reset_store got=%b exp=%b", mem_we, 1'b1); end
    reset = 1'b1;
    run = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we_gate got=%b exp=%b", mem_we, 1'b0); end
    tick();
    run = 1'b0;
    checks++; if ({pc_out, ac_out, ir_out, mem_addr, halted, illegal} !== 62'h0) begin fails++; $display("FAIL reset_mid_regs got=%h exp=%h", {pc_out, ac_out, ir_out, mem_addr, halted, illegal}, 62'h0); end
    checks++; if ({mem[12'h030], we_cnt[7:0]} !== {16'h1234, 8'h00}) begin fails++; $display("FAIL reset_mid_mem got=%h exp=%h", {mem[12'h030], we_cnt[7:0]}, {16'h1234, 8'h00}); end
  endtask
  initial begin
    test_reset();
    test_loadi_store();
    test_load_alu();
    test_jz();
    test_pc_wrap();
    test_illegal();
    test_reset_in_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port run, input, 1 bit: start pulse, sampled in IDLE only.
REQ-005 SHALL have port mem_addr, output, 16 bits: main memory address, {4'b0, 12-bit addr}.
REQ-006 SHALL have port mem_wdata, output, 16 bits: main memory write data.
REQ-007 SHALL have port mem_we, output, 1 bit: main memory write enable.
REQ-008 SHALL have port mem_rdata, input, 16 bits: memory read data, valid the cycle after the address is presented with mem_we=0.
REQ-009 SHALL have port alu_opcode, output, 4 bits: ALU operation select.
REQ-010 SHALL have port alu_a, output, 16 bits: ALU operand1, always equal to AC.
REQ-011 SHALL have port alu_b, output, 16 bits: ALU operand2, always equal to mem_rdata.
REQ-012 SHALL have port alu_result, input, 16 bits: combinational ALU result.
REQ-013 SHALL have ports pc_out (12), ac_out (16) and ir_out (16), outputs: architectural registers.
REQ-014 SHALL have ports halted and illegal, outputs, 1 bit each: status flags.

Function
REQ-015 Instruction format SHALL be op=ir[15:12] and addr=ir[11:0]; ALU instructions SHALL use ir[11:8] as alu_op and ir[7:0] as a zero-extended operand address.
REQ-016 Opcodes SHALL be: 0 HALT, 1 LOAD (AC<=M[addr]), 2 STORE (M[addr]<=AC), 3 ALU (AC<=ALU(alu_op, AC, M[addr8])), 4 JUMP (PC<=addr), 5 JZ (PC<=addr if AC==0), 6 LOADI (AC<={4'b0,addr}); opcodes 7-F SHALL be illegal.
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, OPFETCH, EXECUTE, STORE and HALT.
REQ-018 IDLE: on run=1, go to FETCH; otherwise stay; mem_we=0.
REQ-019 FETCH: mem_addr={4'b0,PC}, mem_we=0; next state DECODE.
REQ-020 DECODE: IR<=mem_rdata and PC<=PC+1, with 12-bit wrap 12'hFFF->12'h000.
REQ-021 DECODE, LOAD or ALU: go to OPFETCH; STORE: go to STORE.
REQ-022 DECODE, JUMP, taken JZ or LOADI: execute in this cycle and return to FETCH; a jump target SHALL override the increment.
REQ-023 DECODE, not-taken JZ: PC+1, then FETCH; JZ SHALL test the AC value held during DECODE.
REQ-024 DECODE, HALT: go to HALT; illegal opcode: go to HALT and set illegal<=1.
REQ-025 OPFETCH: mem_addr = operand address, mem_we=0; next state EXECUTE.
REQ-026 EXECUTE: LOAD sets AC<=mem_rdata; ALU sets AC<=alu_result with alu_opcode=IR[11:8]; next state FETCH.
REQ-027 alu_opcode SHALL be IR[11:8] in all states, and AC SHALL change only in EXECUTE and on LOADI.
REQ-028 STORE: mem_addr={4'b0,addr}, mem_wdata=AC, mem_we=1 for exactly this one cycle; next state FETCH.
REQ-029 mem_we SHALL be 1 only in STORE and SHALL be forced 0 in any cycle where reset=1.
REQ-030 mem_wdata SHALL equal AC in all states.
REQ-031 HALT: halted=1; the FSM SHALL remain in HALT until reset, and run SHALL be ignored there.
REQ-032 run SHALL be ignored in every state except IDLE.
REQ-033 Instruction latency SHALL be: JUMP/JZ/LOADI/HALT 2 cycles; STORE 3 cycles; LOAD/ALU 4 cycles, counted FETCH-to-next-FETCH.
REQ-034 All arithmetic SHALL wrap modulo its width, and no overflow flag SHALL exist.

Reset
REQ-035 reset SHALL take priority over every other input, including reset asserted mid-instruction.
REQ-036 On reset the outputs SHALL be: state=IDLE, PC=RESET_PC, AC=0, IR=0, halted=0, illegal=0, mem_we=0, mem_addr=0.
REQ-037 No partially executed instruction SHALL commit any register or memory write after the reset edge.

Verification
REQ-038 Memory {0:16'h6005, 1:16'h200A, 2:16'h0000}, run pulse -> AC=5 after 2 cycles, M[10]=5 with one mem_we cycle, halted=1, PC=3.
REQ-039 M[0]=16'h1010, M[1]=16'h3014, M[16]=7, M[20]=3 -> AC=7, then AC=10 after the ALU add; alu_opcode=0 during EXECUTE.
REQ-040 AC=0 then JZ 16'h5040 -> PC=0x040; AC=1 then same JZ -> PC=previous PC+1.
REQ-041 PC=12'hFFF holding 16'h6001 -> after DECODE PC=0x000 and AC=1.
REQ-042 M[0]=16'h7000 -> halted=1, illegal=1, and later run pulses are ignored.
REQ-043 reset asserted in the STORE cycle -> mem_we=0 that cycle, memory unchanged, and all registers at reset values next cycle.
